// File: rtl/wb_l2_arbiter.sv
// wb_l2_arbiter
// Round-robin Wishbone arbiter that shares one L2 port between the icache
// and the dcache. Each owner gets one SETUP cycle (grant up, l2_cyc low)
// before its CONNECT phase, which guarantees a one-cycle bubble between owners.
// ACK, RTY and DAT_S pass straight through to the owner while connected.
// Forwarded RTYs are counted in a saturating counter.
// Optional feature: define WB_ARB_TIMEOUT_EN to add a watchdog that aborts a
// CONNECT phase after TIMEOUT_CYCLES cycles with no ACK or RTY. The abort
// answers the owner with RTY and sets the sticky timeout_err flag.

module wb_l2_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 128,
    parameter int SEL_W          = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RTY_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // icache master port
    input  logic                 i_cyc,
    input  logic                 i_stb,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_adr,
    input  logic [SEL_W-1:0]     i_sel,
    input  logic [DATA_W-1:0]    i_dat_m,
    output logic                 i_ack,
    output logic                 i_rty,
    output logic [DATA_W-1:0]    i_dat_s,
    // dcache master port
    input  logic                 d_cyc,
    input  logic                 d_stb,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_adr,
    input  logic [SEL_W-1:0]     d_sel,
    input  logic [DATA_W-1:0]    d_dat_m,
    output logic                 d_ack,
    output logic                 d_rty,
    output logic [DATA_W-1:0]    d_dat_s,
    // shared L2 slave port
    output logic                 l2_cyc,
    output logic                 l2_stb,
    output logic                 l2_we,
    output logic [ADDR_W-1:0]    l2_adr,
    output logic [SEL_W-1:0]     l2_sel,
    output logic [DATA_W-1:0]    l2_dat_m,
    input  logic                 l2_ack,
    input  logic                 l2_rty,
    input  logic [DATA_W-1:0]    l2_dat_s,
    // status
    output logic [1:0]           grant,
    output logic [RTY_CNT_W-1:0] rty_count,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_CONNECT = 2'd2
    } state_t;

    // Owner and last-served encoding: 0 = icache, 1 = dcache.
    state_t                 r_state;
    logic                   r_own;
    logic                   r_last;
    logic [1:0]             r_grant;
    logic [RTY_CNT_W-1:0]   r_rty_count;

    logic w_req_i;
    logic w_req_d;
    logic w_pick;
    logic w_own_cyc;
    logic w_own_stb;
    logic w_other_req;
    logic w_conn;
    logic w_timeout;
    logic w_live;
    logic w_own_ack;
    logic w_own_rty;

    assign w_req_i     = i_cyc & i_stb;
    assign w_req_d     = d_cyc & d_stb;
    // On a tie the requester that was not served last wins.
    assign w_pick      = (w_req_i & w_req_d) ? ~r_last : w_req_d;
    assign w_own_cyc   = r_own ? d_cyc : i_cyc;
    assign w_own_stb   = r_own ? d_stb : i_stb;
    assign w_other_req = r_own ? w_req_i : w_req_d;

    // A CONNECT cycle is live only while the owner holds cyc and the
    // watchdog has not fired; an owner dropping cyc kills l2_cyc at once.
    assign w_conn    = (r_state == ST_CONNECT) & w_own_cyc;
    assign w_live    = w_conn & ~w_timeout;
    assign w_own_ack = w_live & l2_ack;
    assign w_own_rty = (w_live & l2_rty & ~l2_ack) | w_timeout;

    assign l2_cyc  = w_live;
    assign l2_stb  = w_live & w_own_stb;

    assign i_ack   = w_own_ack & ~r_own;
    assign i_rty   = w_own_rty & ~r_own;
    assign d_ack   = w_own_ack & r_own;
    assign d_rty   = w_own_rty & r_own;
    assign i_dat_s = (w_conn & ~r_own) ? l2_dat_s : '0;
    assign d_dat_s = (w_conn & r_own) ? l2_dat_s : '0;

    assign grant     = r_grant;
    assign rty_count = r_rty_count;

    // Steer the owner's address, select, write data and direction to L2 once a grant exists.
    always_comb begin
        l2_we    = 1'b0;
        l2_adr   = '0;
        l2_sel   = '0;
        l2_dat_m = '0;
        if (r_state != ST_IDLE) begin
            l2_we    = r_own ? d_we    : i_we;
            l2_adr   = r_own ? d_adr   : i_adr;
            l2_sel   = r_own ? d_sel   : i_sel;
            l2_dat_m = r_own ? d_dat_m : i_dat_m;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout_err;

    assign w_timeout   = w_conn & (r_wdog == WDOG_W'(TIMEOUT_CYCLES));
    assign timeout_err = r_timeout_err;

    // Watchdog: count silent CONNECT cycles from zero, then latch the sticky error when it fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_SETUP) begin
                r_wdog <= '0;
            end else if ((r_state == ST_CONNECT) && !l2_ack && !l2_rty &&
                         (r_wdog != WDOG_W'(TIMEOUT_CYCLES))) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM: picks the owner, holds grant through SETUP/CONNECT and handles every CONNECT exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_own       <= 1'b0;
            r_last      <= 1'b1;
            r_grant     <= 2'b00;
            r_rty_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_i | w_req_d) begin
                        r_own   <= w_pick;
                        r_grant <= w_pick ? 2'b10 : 2'b01;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_CONNECT;
                end
                ST_CONNECT: begin
                    if (!w_own_cyc) begin
                        r_grant <= 2'b00;
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_last  <= r_own;
                        r_grant <= 2'b00;
                        r_state <= ST_IDLE;
                    end else if (l2_ack) begin
                        r_last <= r_own;
                        if (w_other_req) begin
                            r_own   <= ~r_own;
                            r_grant <= r_own ? 2'b01 : 2'b10;
                            r_state <= ST_SETUP;
                        end else begin
                            r_grant <= 2'b00;
                            r_state <= ST_IDLE;
                        end
                    end else if (l2_rty) begin
                        if (r_rty_count != '1) begin
                            r_rty_count <= r_rty_count + 1'b1;
                        end
                        r_last  <= r_own;
                        r_grant <= 2'b00;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_l2_arbiter.sv
// Self-checking bench for wb_l2_arbiter: directed scenarios for the main
// arbitration cases plus a randomized phase, all compared against a
// transaction-rule reference model. The watchdog scenario is built only when
// WB_ARB_TIMEOUT_EN is defined; otherwise the bench checks that CONNECT waits.

module tb_wb_l2_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 128;
    localparam int SW   = 16;
    localparam int TO   = 8;
    localparam int RW   = 8;
    localparam int RMAX = (1 << RW) - 1;
    localparam logic [DW-1:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          iCyc, iStb, iWe, dCyc, dStb, dWe, l2Ack, l2Rty;
    logic [AW-1:0] iAdr, dAdr;
    logic [SW-1:0] iSel, dSel;
    logic [DW-1:0] iDatM, dDatM, l2DatS;

    logic          iAck, iRty, dAck, dRty, l2Cyc, l2Stb, l2We, timeoutErr;
    logic [DW-1:0] iDatS, dDatS, l2DatM;
    logic [AW-1:0] l2Adr;
    logic [SW-1:0] l2Sel;
    logic [1:0]    grant;
    logic [RW-1:0] rtyCount;

    wb_l2_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT_CYCLES(TO), .RTY_CNT_W(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(iCyc), .i_stb(iStb), .i_we(iWe), .i_adr(iAdr), .i_sel(iSel), .i_dat_m(iDatM),
        .i_ack(iAck), .i_rty(iRty), .i_dat_s(iDatS),
        .d_cyc(dCyc), .d_stb(dStb), .d_we(dWe), .d_adr(dAdr), .d_sel(dSel), .d_dat_m(dDatM),
        .d_ack(dAck), .d_rty(dRty), .d_dat_s(dDatS),
        .l2_cyc(l2Cyc), .l2_stb(l2Stb), .l2_we(l2We), .l2_adr(l2Adr), .l2_sel(l2Sel),
        .l2_dat_m(l2DatM), .l2_ack(l2Ack), .l2_rty(l2Rty), .l2_dat_s(l2DatS),
        .grant(grant), .rty_count(rtyCount), .timeout_err(timeoutErr)
    );

    int vecCount = 0;
    int missCount = 0;

    // Reference model: phase 0 idle, 1 setup, 2 connect; owner 0 icache, 1 dcache.
    int mPhase, mOwn, mLast, mRty, mWd;
    bit mTerr;

    // Snapshot of DUT outputs taken at the last sampling point.
    logic [1:0]    sGrant;
    logic          sCyc, sStb, sIAck, sIRty, sDAck, sDRty;
    logic [DW-1:0] sIDat, sDDat;
    logic [RW-1:0] sRty;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        mPhase = 0; mOwn = 0; mLast = 1; mRty = 0; mWd = 0; mTerr = 1'b0;
    endfunction

    task automatic idleAll();
        iCyc = 0; iStb = 0; iWe = 0; iAdr = '0; iSel = '0; iDatM = '0;
        dCyc = 0; dStb = 0; dWe = 0; dAdr = '0; dSel = '0; dDatM = '0;
        l2Ack = 0; l2Rty = 0; l2DatS = '0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        idleAll();
        #1;
        checkOutput("rst_ctrl", {grant, l2Cyc, l2Stb, l2We, iAck, iRty, dAck, dRty, timeoutErr}, '0);
        checkOutput("rst_rty_count", rtyCount, '0);
        modelReset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock: sample at the falling edge, compare with the model, advance the model, return at posedge+1.
    task automatic applyStimulus();
        bit reqI, reqD, oCyc, oStb, conn, hit, live, oAck, oRty;
        logic [1:0]    eGrant;
        logic          eWe;
        logic [AW-1:0] eAdr;
        logic [SW-1:0] eSel;
        logic [DW-1:0] eDatM, eIDat, eDDat;
        logic [9:0]    eCtrl, aCtrl;
        @(negedge clk);
        reqI = iCyc && iStb;
        reqD = dCyc && dStb;
        oCyc = (mOwn == 1) ? dCyc : iCyc;
        oStb = (mOwn == 1) ? dStb : iStb;
        conn = (mPhase == 2) && oCyc;
`ifdef WB_ARB_TIMEOUT_EN
        hit = conn && (mWd == TO);
`else
        hit = 1'b0;
`endif
        live = conn && !hit;
        oAck = live && l2Ack;
        oRty = (live && l2Rty && !l2Ack) || hit;
        eGrant = (mPhase == 0) ? 2'b00 : ((mOwn == 1) ? 2'b10 : 2'b01);
        eWe    = (mPhase == 0) ? 1'b0 : ((mOwn == 1) ? dWe   : iWe);
        eAdr   = (mPhase == 0) ? '0   : ((mOwn == 1) ? dAdr  : iAdr);
        eSel   = (mPhase == 0) ? '0   : ((mOwn == 1) ? dSel  : iSel);
        eDatM  = (mPhase == 0) ? '0   : ((mOwn == 1) ? dDatM : iDatM);
        eIDat  = (conn && mOwn == 0) ? l2DatS : '0;
        eDDat  = (conn && mOwn == 1) ? l2DatS : '0;
        eCtrl  = {eGrant, live, live && oStb, eWe, oAck && mOwn == 0, oRty && mOwn == 0,
                  oAck && mOwn == 1, oRty && mOwn == 1, mTerr};
        aCtrl  = {grant, l2Cyc, l2Stb, l2We, iAck, iRty, dAck, dRty, timeoutErr};
        sGrant = grant; sCyc = l2Cyc; sStb = l2Stb; sIAck = iAck; sIRty = iRty;
        sDAck = dAck; sDRty = dRty; sIDat = iDatS; sDDat = dDatS; sRty = rtyCount;
        checkOutput("ctrl", 128'(aCtrl), 128'(eCtrl));
        checkOutput("l2_adr", l2Adr, eAdr);
        checkOutput("l2_sel", l2Sel, eSel);
        checkOutput("l2_dat_m", l2DatM, eDatM);
        checkOutput("i_dat_s", iDatS, eIDat);
        checkOutput("d_dat_s", dDatS, eDDat);
        checkOutput("rty_count", rtyCount, mRty);
        case (mPhase)
            0: if (reqI || reqD) begin
                   mOwn = (reqI && reqD) ? 1 - mLast : (reqD ? 1 : 0);
                   mPhase = 1;
               end
            1: begin mPhase = 2; mWd = 0; end
            default: begin
                if (!oCyc) mPhase = 0;
                else if (hit) begin mTerr = 1'b1; mLast = mOwn; mPhase = 0; end
                else if (l2Ack) begin
                    mLast = mOwn;
                    if ((mOwn == 1) ? reqI : reqD) begin mOwn = 1 - mOwn; mPhase = 1; end
                    else mPhase = 0;
                end else if (l2Rty) begin
                    if (mRty < RMAX) mRty++;
                    mLast = mOwn; mPhase = 0;
                end else mWd++;
            end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic testSingleRead();
        doReset();
        iCyc = 1; iStb = 1; iWe = 0; iAdr = 12'h040; iSel = '1; iDatM = {4{$urandom}};
        dAdr = 12'h3C0; dSel = 16'h00FF; dDatM = {4{$urandom}};
        for (int c = 0; c < 8; c++) begin
            l2Ack  = (c == 4);
            l2DatS = (c == 4) ? DEAD : '0;
            if (c == 5) begin iCyc = 0; iStb = 0; end
            if (c == 6) begin iCyc = 1; iStb = 1; dCyc = 1; dStb = 1; end
            applyStimulus();
            case (c)
                0: checkOutput("t1_idle_grant", sGrant, 2'b00);
                1: begin checkOutput("t1_setup_grant", sGrant, 2'b01); checkOutput("t1_setup_cyc", sCyc, 1'b0); end
                2: checkOutput("t1_strobe", sStb, 1'b1);
                4: begin checkOutput("t1_ack", sIAck, 1'b1); checkOutput("t1_dat", sIDat, DEAD); end
                5: checkOutput("t1_back_idle", sGrant, 2'b00);
                7: checkOutput("t1_pair_dfirst", sGrant, 2'b10);
                default: ;
            endcase
        end
    endtask

    task automatic testTie();
        doReset();
        iCyc = 1; iStb = 1; dCyc = 1; dStb = 1; iAdr = 12'h111; dAdr = 12'h222;
        for (int c = 0; c < 8; c++) begin
            l2Ack = (c == 3) || (c == 6);
            l2DatS = {4{$urandom}};
            if (c == 4) begin iCyc = 0; iStb = 0; end
            if (c == 7) begin dCyc = 0; dStb = 0; end
            applyStimulus();
            case (c)
                2: checkOutput("t2_i_first", sGrant, 2'b01);
                3: checkOutput("t2_i_ack", sIAck, 1'b1);
                4: begin checkOutput("t2_bubble", sCyc, 1'b0); checkOutput("t2_d_setup", sGrant, 2'b10); end
                5: checkOutput("t2_d_connect", {sGrant, sCyc}, 3'b101);
                6: checkOutput("t2_d_ack", sDAck, 1'b1);
                7: checkOutput("t2_idle", sGrant, 2'b00);
                default: ;
            endcase
        end
    endtask

    task automatic testRetry();
        doReset();
        dCyc = 1; dStb = 1; dAdr = 12'h0AA; dWe = 1; dDatM = {4{$urandom}};
        l2Rty = 1;
        for (int c = 0; c < 910; c++) begin
            applyStimulus();
            case (c)
                0: checkOutput("t3_rty_start", sRty, 8'd0);
                1: checkOutput("t3_setup_no_rty", sDRty, 1'b0);
                2: begin checkOutput("t3_d_rty", sDRty, 1'b1); checkOutput("t3_cnt_before", sRty, 8'd0); end
                3: begin checkOutput("t3_cnt_after", sRty, 8'd1); checkOutput("t3_idle", sGrant, 2'b00); end
                4: checkOutput("t3_regrant", sGrant, 2'b10);
                909: checkOutput("t3_saturate", sRty, 8'd255);
                default: ;
            endcase
        end
    endtask

    task automatic testAbort();
        doReset();
        iCyc = 1; iStb = 1; iAdr = 12'h7F0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin iCyc = 0; l2Ack = 1; end
            if (c == 4) l2Ack = 0;
            applyStimulus();
            case (c)
                2: checkOutput("t4_connect", sCyc, 1'b1);
                3: begin checkOutput("t4_cyc_drop", sCyc, 1'b0); checkOutput("t4_no_ack", sIAck, 1'b0); end
                4: checkOutput("t4_grant_off", sGrant, 2'b00);
                5: checkOutput("t4_rty_same", sRty, 8'd0);
                default: ;
            endcase
        end
    endtask

    task automatic testResetMid();
        doReset();
        iCyc = 1; iStb = 1; iAdr = 12'h321;
        for (int c = 0; c < 3; c++) applyStimulus();
        l2Ack = 1; dCyc = 1; dStb = 1;
        #1;
        checkOutput("t5_pre_cyc", l2Cyc, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async", {l2Cyc, l2Stb, grant, iAck}, 5'b0);
        modelReset();
        l2Ack = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            if (c == 1) checkOutput("t5_i_wins", sGrant, 2'b01);
        end
    endtask

    task automatic testTimeout();
        doReset();
        iCyc = 1; iStb = 1; dCyc = 1; dStb = 1;
        for (int c = 0; c < 15; c++) begin
`ifdef WB_ARB_TIMEOUT_EN
            if (c == 11) begin iCyc = 0; iStb = 0; end
            applyStimulus();
            case (c)
                9:  checkOutput("t6_not_yet", sIRty, 1'b0);
                10: begin checkOutput("t6_rty", sIRty, 1'b1); checkOutput("t6_cyc_off", sCyc, 1'b0); end
                11: checkOutput("t6_err", timeoutErr, 1'b1);
                12: checkOutput("t6_d_next", sGrant, 2'b10);
                14: checkOutput("t6_err_held", {timeoutErr, sRty}, 9'h100);
                default: ;
            endcase
`else
            applyStimulus();
            if (c == 14) checkOutput("t6_waits", {sGrant, sCyc, timeoutErr}, 4'b0110);
`endif
        end
    endtask

    task automatic testRandom();
        bit iAct, dAct;
        int r;
        doReset();
        iAct = 0; dAct = 0;
        sIAck = 0; sIRty = 0; sDAck = 0; sDRty = 0;
        for (int c = 0; c < 2000; c++) begin
            if (iAct && (sIAck || sIRty)) iAct = 0;
            else if (iAct && $urandom_range(99) < 3) iAct = 0;
            else if (!iAct && $urandom_range(99) < 40) begin
                iAct = 1; iWe = 1'($urandom); iAdr = AW'($urandom); iSel = SW'($urandom);
                iDatM = {$urandom, $urandom, $urandom, $urandom};
            end
            if (dAct && (sDAck || sDRty)) dAct = 0;
            else if (dAct && $urandom_range(99) < 3) dAct = 0;
            else if (!dAct && $urandom_range(99) < 40) begin
                dAct = 1; dWe = 1'($urandom); dAdr = AW'($urandom); dSel = SW'($urandom);
                dDatM = {$urandom, $urandom, $urandom, $urandom};
            end
            iCyc = iAct; iStb = iAct ? 1'b1 : 1'($urandom);
            dCyc = dAct; dStb = dAct ? 1'b1 : 1'($urandom);
            #1;
            if (l2Cyc) begin
                r = $urandom_range(99);
                l2Ack = (r < 35) || (r >= 45 && r < 50);
                l2Rty = (r >= 35 && r < 50);
            end else begin
                l2Ack = ($urandom_range(99) < 5);
                l2Rty = 1'b0;
            end
            l2DatS = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus();
        end
    endtask

    initial begin
        idleAll();
        testSingleRead();
        testTie();
        testRetry();
        testAbort();
        testResetMid();
        testTimeout();
        testRandom();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/wb_l2_arbiter.md
# wb_l2_arbiter

Round-robin Wishbone arbiter between the instruction cache, the data cache and the shared L2 port. Grants the L2 bus to one cache at a time with fair alternation under contention. Forwards RTY back to the requester and re-arbitrates after it. Counts retries, and optionally aborts an L2 cycle that never acknowledges.

## Interface
- ADDR_W, 12: line address width (ADR)
- DATA_W, 128: line data width (DAT_M/DAT_S)
- SEL_W, 16: byte-select width
- TIMEOUT_CYCLES, 64: CONNECT cycles without ACK/RTY before abort (watchdog builds only)
- RTY_CNT_W, 8: retry counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_cyc, i_stb, i_we  in  1 each  icache master strobes
- i_adr  in  ADDR_W; i_sel  in  SEL_W; i_dat_m  in  DATA_W  icache request
- i_ack, i_rty  out  1 each; i_dat_s  out  DATA_W  icache response
- d_cyc, d_stb, d_we, d_adr, d_sel, d_dat_m, d_ack, d_rty, d_dat_s  dcache port, same directions and widths as the icache port
- l2_cyc, l2_stb, l2_we  out  1 each; l2_adr  out  ADDR_W; l2_sel  out  SEL_W; l2_dat_m  out  DATA_W  L2 request
- l2_ack, l2_rty  in  1 each; l2_dat_s  in  DATA_W  L2 response
- grant  out  2  one-hot owner, bit0 icache, bit1 dcache, 0 when idle
- rty_count  out  RTY_CNT_W  saturating count of forwarded RTYs
- timeout_err  out  1  sticky, set on watchdog abort

## Operation
- A requester is "requesting" when cyc&stb is high.
- States: IDLE, SETUP, CONNECT, registered; owner register `own` (I/D); last-served register `last`.
- IDLE:
  - one requester → own=it, go SETUP.
  - both → own = the one not equal to `last`, go SETUP.
  - none → stay.
- SETUP: grant asserted; l2_cyc/l2_stb=0; l2_adr/sel/dat_m/we driven from owner. Go CONNECT unconditionally.
- CONNECT:
  - l2 request outputs mirror the owner combinationally.
  - Owner ack/rty/dat_s mirror L2 combinationally.
  - Non-owner ack=rty=0, dat_s=0.
- CONNECT exit on l2_ack:
  - `last`=own.
  - If the other requester is requesting: own=other, go SETUP. Otherwise go IDLE.
- CONNECT exit on l2_rty:
  - RTY is forwarded; rty_count +1, saturating at all-ones.
  - `last`=own, go IDLE, so the other requester wins a tie next.
- l2_ack and l2_rty together: treat as ACK; count not incremented.
- Owner drops cyc in CONNECT (abort): l2_cyc falls the same cycle; go IDLE; `last` unchanged.
- IDLE and SETUP: every ack/rty output and l2_cyc/l2_stb is 0; dat outputs are 0.
- Reset values:
  - state=IDLE, grant=0, rty_count=0, timeout_err=0, `last`=D (icache wins the first tie).
  - All outputs 0.
- Reset asserted mid-CONNECT: l2_cyc/l2_stb drop immediately (asynchronous); no ACK is forwarded.

## Timing
- Request high before edge k in IDLE → SETUP in cycle k+1 → CONNECT in k+2, with l2_cyc/l2_stb high.
- Request-to-strobe latency is 2 cycles.
- ACK/RTY/DAT_S pass L2 → owner with zero latency in CONNECT.
- Back-to-back handoff: the ACK cycle is followed by 1 SETUP cycle, then the other owner's CONNECT. A 1-cycle bubble with l2_cyc=0 is guaranteed between owners.
- grant changes only on clock edges and is stable through SETUP and CONNECT.
- Every transaction in this build is a single-beat line transfer; no burst or lock.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A cycle counter of width clog2(TIMEOUT_CYCLES+1) is cleared on entry to CONNECT and increments each CONNECT cycle without l2_ack/l2_rty.
  - In the cycle the count equals TIMEOUT_CYCLES: owner rty=1 for that one cycle, l2_cyc/l2_stb forced 0, timeout_err set, `last`=own, go IDLE.
  - rty_count does not increment on a timeout abort.
  - timeout_err clears only on reset.
- Undefined: no counter; CONNECT waits indefinitely; timeout_err tied 0.

## Test plan
- Single icache read: i_cyc=i_stb=1, i_adr=0x040 at cycle 0; l2_ack with l2_dat_s=0xDEADBEEF… at cycle 4 → l2_stb high cycles 2–4, grant=01, i_ack=1 and i_dat_s matches at cycle 4, state IDLE at cycle 5.
- Simultaneous requests after reset: both request at cycle 0, L2 acks 1 cycle after each strobe → icache served first (grant=01), l2_cyc=0 in cycle 4, dcache CONNECT from cycle 5 (grant=10). Next simultaneous pair → dcache first.
- Retry: dcache alone, L2 answers l2_rty=1 → d_rty=1 that cycle, rty_count 0→1, re-grant after IDLE+SETUP. 300 retries → rty_count saturates at 255.
- Abort: icache drops i_cyc in the 2nd CONNECT cycle → l2_cyc=0 the same cycle, grant=00 next cycle, rty_count unchanged.
- Reset mid-transfer: rst_n low during CONNECT → l2_cyc, grant, acks 0 immediately. After release, pending icache+dcache requests → icache wins.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, L2 never responds → i_rty=1 exactly at CONNECT cycle 8, timeout_err=1 and held. A pending dcache request is granted next.
